// File: rtl/ysyx_25040129_idu_pipe.sv
// ysyx_25040129_idu_pipe: buffered decode stage between IFU and EXU.
// Instructions are decoded as they are enqueued, and the decoded bundles are
// held in a FIFO_DEPTH-entry FIFO whose head is offered to EXU.
// Optional feature macro: IDU_ZICSR_EN enables CSR instruction decode. When it
// is undefined, every SYSTEM op with funct3 != 000 is flagged illegal.
module ysyx_25040129_idu_pipe #(
  parameter int XLEN       = 32,
  parameter int PC_W       = 32,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              flush,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [31:0]                       in_inst,
  input  logic [PC_W-1:0]                   in_pc,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [PC_W-1:0]                   out_pc,
  output logic [XLEN-1:0]                   out_imm,
  output logic [4:0]                        out_rs1,
  output logic [4:0]                        out_rs2,
  output logic [4:0]                        out_rd,
  output logic [6:0]                        out_opcode,
  output logic [2:0]                        out_funct3,
  output logic [6:0]                        out_funct7,
  output logic                              out_reg_write,
  output logic                              out_ecall,
  output logic                              out_ebreak,
  output logic                              out_mret,
  output logic                              out_csr_write,
  output logic                              out_csr_read,
  output logic                              out_illegal,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   count
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef struct packed {
    logic [PC_W-1:0]        pc;
    logic signed [XLEN-1:0] imm;
    logic [4:0]             rs1;
    logic [4:0]             rs2;
    logic [4:0]             rd;
    logic [6:0]             opcode;
    logic [2:0]             funct3;
    logic [6:0]             funct7;
    logic                   reg_write;
    logic                   ecall;
    logic                   ebreak;
    logic                   mret;
    logic                   csr_write;
    logic                   csr_read;
    logic                   illegal;
  } bundle_t;

  // All RV32 immediates are first assembled as 32-bit signed values, then
  // widened (or narrowed) to the datapath width.
  function automatic logic signed [XLEN-1:0] sext_xlen(input logic signed [31:0] v);
    return XLEN'(v);
  endfunction

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  logic [CNT_W-1:0]   cnt;
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic               vld_p0;
  logic               deq;
  bundle_t            bundle_p0;
  bundle_t            fifo_p1 [FIFO_DEPTH];
  bundle_t            head_p1;

  logic signed [31:0] imm_i;
  logic signed [31:0] imm_s;
  logic signed [31:0] imm_b;
  logic signed [31:0] imm_j;
  logic signed [31:0] imm_u;
  logic signed [31:0] imm_raw;
  logic               reg_write_raw;

  assign imm_i = {{20{in_inst[31]}}, in_inst[31:20]};
  assign imm_s = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
  assign imm_b = {{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
  assign imm_j = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};
  assign imm_u = {in_inst[31:12], 12'b0};

  assign in_ready  = (cnt < CNT_W'(FIFO_DEPTH)) && !flush;
  assign vld_p0    = in_valid && in_ready;
  assign out_valid = (cnt != '0);
  assign deq       = out_valid && out_ready;
  assign count     = cnt;

  // ---- stage p0: decode the incoming instruction before it is enqueued ----
  // Illegal bundles carry imm=0 and no write/strobe so EXU never acts on them.
  always_comb begin
    bundle_p0        = '0;
    imm_raw          = '0;
    reg_write_raw    = 1'b0;
    bundle_p0.pc     = in_pc;
    bundle_p0.rs1    = in_inst[19:15];
    bundle_p0.rs2    = in_inst[24:20];
    bundle_p0.rd     = in_inst[11:7];
    bundle_p0.opcode = in_inst[6:0];
    bundle_p0.funct3 = in_inst[14:12];
    bundle_p0.funct7 = in_inst[31:25];
    case (in_inst[6:0])
      OPC_OP_IMM, OPC_LOAD, OPC_JALR: begin
        imm_raw       = imm_i;
        reg_write_raw = 1'b1;
      end
      OPC_STORE:  imm_raw = imm_s;
      OPC_BRANCH: imm_raw = imm_b;
      OPC_JAL: begin
        imm_raw       = imm_j;
        reg_write_raw = 1'b1;
      end
      OPC_LUI, OPC_AUIPC: begin
        imm_raw       = imm_u;
        reg_write_raw = 1'b1;
      end
      OPC_OP: reg_write_raw = 1'b1;
      OPC_SYSTEM: begin
        imm_raw = imm_i;
        if (in_inst[14:12] == 3'b000) begin
          if (in_inst[19:15] != 5'd0 || in_inst[11:7] != 5'd0)
            bundle_p0.illegal = 1'b1;
          else if (in_inst[31:20] == 12'h000)
            bundle_p0.ecall = 1'b1;
          else if (in_inst[31:20] == 12'h001)
            bundle_p0.ebreak = 1'b1;
          else if (in_inst[31:20] == 12'h302)
            bundle_p0.mret = 1'b1;
          else
            bundle_p0.illegal = 1'b1;
        end else begin
`ifdef IDU_ZICSR_EN
          case (in_inst[14:12])
            3'b001, 3'b101: begin
              bundle_p0.csr_write = 1'b1;
              reg_write_raw       = 1'b1;
            end
            3'b010, 3'b011, 3'b110, 3'b111: begin
              bundle_p0.csr_read  = 1'b1;
              bundle_p0.csr_write = (in_inst[19:15] != 5'd0);
              reg_write_raw       = 1'b1;
            end
            default: bundle_p0.illegal = 1'b1;
          endcase
`else
          bundle_p0.illegal = 1'b1;
`endif
        end
      end
      default: bundle_p0.illegal = 1'b1;
    endcase
    if (bundle_p0.illegal) begin
      imm_raw       = '0;
      reg_write_raw = 1'b0;
    end
    bundle_p0.imm       = sext_xlen(imm_raw);
    bundle_p0.reg_write = reg_write_raw && (in_inst[11:7] != 5'd0);
  end

  // ---- stage p1: FIFO control (pointers and occupancy); reset beats flush ----
  always_ff @(posedge clock) begin
    if (reset || flush) begin
      cnt    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (vld_p0) wr_ptr <= ptr_next(wr_ptr);
      if (deq)    rd_ptr <= ptr_next(rd_ptr);
      case ({vld_p0, deq})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Bundle storage: data only, written on every accepted enqueue.
  always_ff @(posedge clock) begin
    if (vld_p0 && !reset) fifo_p1[wr_ptr] <= bundle_p0;
  end

  // Head bundle reads as zero while the FIFO is empty (pc passes through).
  always_comb begin
    head_p1 = out_valid ? fifo_p1[rd_ptr] : '0;
  end

  assign out_pc        = fifo_p1[rd_ptr].pc;
  assign out_imm       = head_p1.imm;
  assign out_rs1       = head_p1.rs1;
  assign out_rs2       = head_p1.rs2;
  assign out_rd        = head_p1.rd;
  assign out_opcode    = head_p1.opcode;
  assign out_funct3    = head_p1.funct3;
  assign out_funct7    = head_p1.funct7;
  assign out_reg_write = head_p1.reg_write;
  assign out_ecall     = head_p1.ecall;
  assign out_ebreak    = head_p1.ebreak;
  assign out_mret      = head_p1.mret;
  assign out_csr_write = head_p1.csr_write;
  assign out_csr_read  = head_p1.csr_read;
  assign out_illegal   = head_p1.illegal;

endmodule

// File: tb/tb_ysyx_25040129_idu_pipe.sv
// Self-checking bench for ysyx_25040129_idu_pipe: directed scenarios followed
// by randomized traffic, compared against a queue-based reference model.
module tb_ysyx_25040129_idu_pipe;
  localparam int XLEN  = 32;
  localparam int PC_W  = 32;
  localparam int DEPTH = 2;
  localparam int CW    = $clog2(DEPTH + 1);

  logic            clock = 1'b0;
  logic            reset, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0]     in_inst;
  logic [PC_W-1:0] in_pc, out_pc;
  logic [XLEN-1:0] out_imm;
  logic [4:0]      out_rs1, out_rs2, out_rd;
  logic [6:0]      out_opcode, out_funct7;
  logic [2:0]      out_funct3;
  logic            out_reg_write, out_ecall, out_ebreak, out_mret;
  logic            out_csr_write, out_csr_read, out_illegal;
  logic [CW-1:0]   count;

  ysyx_25040129_idu_pipe #(.XLEN(XLEN), .PC_W(PC_W), .FIFO_DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_imm(out_imm),
    .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
    .out_opcode(out_opcode), .out_funct3(out_funct3), .out_funct7(out_funct7),
    .out_reg_write(out_reg_write), .out_ecall(out_ecall), .out_ebreak(out_ebreak),
    .out_mret(out_mret), .out_csr_write(out_csr_write), .out_csr_read(out_csr_read),
    .out_illegal(out_illegal), .count(count)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] imm;
    logic [4:0]  rs1, rs2, rd;
    logic [6:0]  opc, f7;
    logic [2:0]  f3;
    logic        rw, ec, eb, mr, cw, cr, il;
  } exp_t;

  exp_t q[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Reference decoder: immediates built arithmetically from the field weights.
  function automatic exp_t ref_decode(input logic [31:0] inst, input logic [31:0] pc);
    exp_t e;
    int   v;
    bit   wr;
    e = '{default: '0};
    wr = 1'b0;
    e.pc = pc; e.rs1 = inst[19:15]; e.rs2 = inst[24:20]; e.rd = inst[11:7];
    e.opc = inst[6:0]; e.f3 = inst[14:12]; e.f7 = inst[31:25];
    case (inst[6:0])
      7'h13, 7'h03, 7'h67: begin
        v = int'(inst[31:20]); if (v >= 2048) v -= 4096;
        e.imm = v; wr = 1'b1;
      end
      7'h23: begin
        v = int'(inst[31:25]) * 32 + int'(inst[11:7]); if (v >= 2048) v -= 4096;
        e.imm = v;
      end
      7'h63: begin
        v = int'(inst[31]) * 4096 + int'(inst[7]) * 2048 + int'(inst[30:25]) * 32 + int'(inst[11:8]) * 2;
        if (v >= 4096) v -= 8192;
        e.imm = v;
      end
      7'h6f: begin
        v = int'(inst[31]) * (1 << 20) + int'(inst[19:12]) * 4096 + int'(inst[20]) * 2048 + int'(inst[30:21]) * 2;
        if (v >= (1 << 20)) v -= (1 << 21);
        e.imm = v; wr = 1'b1;
      end
      7'h37, 7'h17: begin e.imm = int'(inst[31:12]) * 4096; wr = 1'b1; end
      7'h33: wr = 1'b1;
      7'h73: begin
        v = int'(inst[31:20]); if (v >= 2048) v -= 4096;
        e.imm = v;
        if (inst[14:12] == 0) begin
          if (inst[19:15] != 0 || inst[11:7] != 0) e.il = 1'b1;
          else if (inst[31:20] == 12'h000) e.ec = 1'b1;
          else if (inst[31:20] == 12'h001) e.eb = 1'b1;
          else if (inst[31:20] == 12'h302) e.mr = 1'b1;
          else e.il = 1'b1;
        end else begin
`ifdef IDU_ZICSR_EN
          if (inst[14:12] == 1 || inst[14:12] == 5) begin e.cw = 1'b1; wr = 1'b1; end
          else if (inst[14:12] == 4) e.il = 1'b1;
          else begin e.cr = 1'b1; e.cw = (inst[19:15] != 0); wr = 1'b1; end
`else
          e.il = 1'b1;
`endif
        end
      end
      default: e.il = 1'b1;
    endcase
    if (e.il) begin e.imm = 0; wr = 1'b0; end
    e.rw = wr && (inst[11:7] != 0);
    return e;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    exp_t e;
    e = '{default: '0};
    chk("count", 64'(count), 64'(q.size()));
    chk("out_valid", 64'(out_valid), 64'(q.size() > 0));
    if (q.size() > 0) begin
      e = q[0];
      chk("out_pc", 64'(out_pc), 64'(e.pc));
    end
    chk("out_imm", 64'(out_imm), 64'(e.imm));
    chk("out_rs1", 64'(out_rs1), 64'(e.rs1));
    chk("out_rs2", 64'(out_rs2), 64'(e.rs2));
    chk("out_rd", 64'(out_rd), 64'(e.rd));
    chk("out_opcode", 64'(out_opcode), 64'(e.opc));
    chk("out_funct3", 64'(out_funct3), 64'(e.f3));
    chk("out_funct7", 64'(out_funct7), 64'(e.f7));
    chk("out_reg_write", 64'(out_reg_write), 64'(e.rw));
    chk("strobes", 64'({out_ecall, out_ebreak, out_mret, out_illegal}), 64'({e.ec, e.eb, e.mr, e.il}));
    chk("csr", 64'({out_csr_write, out_csr_read}), 64'({e.cw, e.cr}));
    chk("one_hot_flags", 64'($countones({out_ecall, out_ebreak, out_mret, out_illegal}) <= 1), 64'(1));
  endtask

  // One clock of stimulus: drive, check handshake, advance model, check outputs.
  task automatic step(input logic v, input logic [31:0] inst, input logic [31:0] pc,
                      input logic ordy, input logic fl, input logic rs);
    bit enq, deq;
    @(negedge clock);
    in_valid = v; in_inst = inst; in_pc = pc; out_ready = ordy; flush = fl; reset = rs;
    #1;
    chk("in_ready", 64'(in_ready), 64'((q.size() < DEPTH) && !fl));
    if (rs || fl) q.delete();
    else begin
      enq = v && (q.size() < DEPTH);
      deq = ordy && (q.size() > 0);
      if (deq) q.delete(0);
      if (enq) q.push_back(ref_decode(inst, pc));
    end
    @(posedge clock);
    #1;
    check_outputs();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r, inst;
    logic [6:0]  opcs [10];
    opcs = '{7'h13, 7'h03, 7'h67, 7'h73, 7'h23, 7'h63, 7'h6f, 7'h37, 7'h17, 7'h33};
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_inst = '0; in_pc = '0; out_ready = 1'b0;
    repeat (2) @(posedge clock);
    step(0, 32'h0, 32'h0, 0, 0, 1);

    // addi x1,x0,-1 visible one cycle after acceptance
    step(1, 32'hFFF00093, 32'h80000000, 1, 0, 0);
    chk("t1_valid", 64'(out_valid), 64'(1));
    chk("t1_imm", 64'(out_imm), 64'h0FFFFFFFF);
    chk("t1_rd", 64'(out_rd), 64'(1));
    chk("t1_rw", 64'(out_reg_write), 64'(1));
    chk("t1_pc", 64'(out_pc), 64'h080000000);

    step(1, 32'hFE000EE3, 32'h80000004, 1, 0, 0);
    chk("t2_beq_imm", 64'(out_imm), 64'h0FFFFFFFC);
    chk("t2_beq_rw", 64'(out_reg_write), 64'(0));
    step(1, 32'h008000EF, 32'h80000008, 1, 0, 0);
    chk("t2_jal_imm", 64'(out_imm), 64'(8));
    chk("t2_jal_rw", 64'(out_reg_write), 64'(1));
    step(1, 32'h00000013, 32'h8000000C, 1, 0, 0);
    chk("t2_addi_x0_rw", 64'(out_reg_write), 64'(0));

    step(1, 32'h00100073, 32'h80000010, 1, 0, 0);
    chk("t3_ebreak", 64'(out_ebreak), 64'(1));
    step(1, 32'h30200073, 32'h80000014, 1, 0, 0);
    chk("t3_mret", 64'(out_mret), 64'(1));
    step(1, 32'h00000073, 32'h80000018, 1, 0, 0);
    chk("t3_ecall", 64'(out_ecall), 64'(1));
    step(1, 32'h10500073, 32'h8000001C, 1, 0, 0);
    chk("t3_wfi_illegal", 64'(out_illegal), 64'(1));
    chk("t3_wfi_strobes", 64'({out_ecall, out_ebreak, out_mret}), 64'(0));

    step(1, 32'h300022F3, 32'h80000020, 1, 0, 0);
`ifdef IDU_ZICSR_EN
    chk("t4_csr_read", 64'(out_csr_read), 64'(1));
    chk("t4_csr_write", 64'(out_csr_write), 64'(0));
    chk("t4_rw", 64'(out_reg_write), 64'(1));
`else
    chk("t4_illegal", 64'(out_illegal), 64'(1));
    chk("t4_csr_read", 64'(out_csr_read), 64'(0));
`endif

    // back-pressure: third back-to-back offer is refused
    step(0, 32'h0, 32'h0, 1, 0, 0);
    step(1, 32'h00100093, 32'h00000100, 0, 0, 0);
    step(1, 32'h00200113, 32'h00000104, 0, 0, 0);
    step(1, 32'h00300193, 32'h00000108, 0, 0, 0);
    chk("t5_count_full", 64'(count), 64'(2));
    chk("t5_in_ready_full", 64'(in_ready), 64'(0));
    chk("t5_head_pc", 64'(out_pc), 64'h100);
    step(0, 32'h0, 32'h0, 1, 0, 0);
    chk("t5_second_pc", 64'(out_pc), 64'h104);
    step(0, 32'h0, 32'h0, 1, 0, 0);
    chk("t5_drained", 64'(count), 64'(0));

    // flush and reset while full
    step(1, 32'h00100093, 32'h00000200, 0, 0, 0);
    step(1, 32'h00200113, 32'h00000204, 0, 0, 0);
    step(1, 32'h00300193, 32'h00000208, 0, 1, 0);
    chk("t6_flush_count", 64'(count), 64'(0));
    chk("t6_flush_valid", 64'(out_valid), 64'(0));
    step(1, 32'h00100093, 32'h00000300, 0, 0, 0);
    step(1, 32'h00200113, 32'h00000304, 0, 0, 0);
    step(1, 32'h00300193, 32'h00000308, 1, 1, 1);
    chk("t6_reset_count", 64'(count), 64'(0));
    chk("t6_reset_valid", 64'(out_valid), 64'(0));

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      r = $urandom();
      if (r[3:0] == 4'd0) inst = $urandom();
      else if (r[3:0] == 4'd1) begin
        inst = $urandom_range(0, 3);
        case (inst[1:0])
          2'd0: inst = 32'h00000073;
          2'd1: inst = 32'h00100073;
          2'd2: inst = 32'h30200073;
          default: inst = 32'h10500073;
        endcase
      end else begin
        inst = $urandom();
        inst[6:0] = opcs[$urandom_range(0, 9)];
      end
      step(r[6:4] != 3'd0, inst, $urandom(), r[7], r[11:8] == 4'd0, r[17:12] == 6'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
